// File: rtl/lb_window_ctrl.sv
// Sequencing controller for a 3x3 line-buffer window generator.
// Primes two rows, then flags stride-aligned windows with back-pressure.
module lb_window_ctrl #(
   parameter int unsigned IMG_WIDTH  = 64,
   parameter int unsigned IMG_HEIGHT = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          stride2,
   input  logic                          pix_valid,
   output logic                          pix_ready,
   output logic                          lb_valid_in,
   output logic                          win_valid,
   input  logic                          win_ready,
   output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
   output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
   output logic                          busy,
   output logic                          frame_done
);

   localparam int unsigned CW = $clog2(IMG_WIDTH);
   localparam int unsigned RW = $clog2(IMG_HEIGHT);

   typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_t;

   state_t        state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          stride_q;
   logic          col_last;
   logic          row_last;
   logic          win_done;

   // Accept handshake and window-completion decode
   always_comb begin
      pix_ready   = ((state == PRIME) || (state == RUN)) && (!win_valid || win_ready);
      lb_valid_in = pix_valid && pix_ready;
      col_last    = (col == CW'(IMG_WIDTH - 1));
      row_last    = (row == RW'(IMG_HEIGHT - 1));
      win_done    = lb_valid_in && (state == RUN) && (col >= CW'(2)) &&
                    (!stride_q || (!col[0] && !row[0]));
      busy        = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         stride_q   <= 1'b0;
         win_valid  <= 1'b0;
         win_col    <= '0;
         win_row    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= PRIME;
                  col      <= '0;
                  row      <= '0;
                  stride_q <= stride2;
               end
            end
            PRIME: begin
               if (lb_valid_in && col_last && (row == RW'(1))) state <= RUN;
            end
            RUN: begin
               if (lb_valid_in && col_last && row_last) state <= FLUSH;
            end
            FLUSH: begin
               if (!win_valid || win_ready) begin
                  state      <= IDLE;
                  frame_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // Raster counters advance only on an accepted pixel
         if (lb_valid_in) begin
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : RW'(row + RW'(1));
            end else begin
               col <= CW'(col + CW'(1));
            end
         end

         // Window indices are pixel position minus the 2-pixel kernel lag, scaled by stride
         if (win_done) begin
            win_valid <= 1'b1;
            win_col   <= CW'(col - CW'(2)) >> stride_q;
            win_row   <= RW'(row - RW'(2)) >> stride_q;
         end else if (win_ready) begin
            win_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/lb_window_ctrl.md
LB_WINDOW_CTRL -- requirements
Module: lb_window_ctrl

Interface
REQ-001 Parameter IMG_WIDTH, default 64, pixels per row; SHALL be >= 3.
REQ-002 Parameter IMG_HEIGHT, default 64, rows per frame; SHALL be >= 3.
REQ-003 Port clk, input, 1, sole clock; all state SHALL change on its rising edge. One clock; reset is asynchronous and active-low.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port start, input, 1, frame start request; sampled only in IDLE.
REQ-006 Port stride2, input, 1, window stride select (0 = stride 1, 1 = stride 2); latched on accepted start.
REQ-007 Port pix_valid, input, 1, upstream pixel present.
REQ-008 Port pix_ready, output, 1, controller accepts a pixel this cycle.
REQ-009 Port lb_valid_in, output, 1, shift strobe to the 3x3 line buffer; equals pix_valid AND pix_ready (combinational).
REQ-010 Port win_valid, output, 1, line-buffer taps hold a complete, stride-aligned 3x3 column.
REQ-011 Port win_ready, input, 1, downstream consumes the window.
REQ-012 Port win_col, output, clog2(IMG_WIDTH), output-window column index (0-based, post-stride).
REQ-013 Port win_row, output, clog2(IMG_HEIGHT), output-window row index (0-based, post-stride).
REQ-014 Port busy, output, 1, high in any state other than IDLE.
REQ-015 Port frame_done, output, 1, single-cycle end-of-frame pulse.

Function
REQ-016 FSM states SHALL be IDLE, PRIME, RUN and FLUSH.
REQ-017 IDLE -> PRIME on start=1: clear pixel counters col and row, latch stride2.
- start SHALL be ignored outside IDLE.
REQ-018 PRIME: rows 0-1 are loaded and no window is produced.
- Transition to RUN on the accept at col=IMG_WIDTH-1, row=1.
REQ-019 RUN -> FLUSH on the accept at col=IMG_WIDTH-1, row=IMG_HEIGHT-1.
REQ-020 FLUSH -> IDLE when win_valid=0, or when win_valid AND win_ready.
- frame_done SHALL pulse high for exactly one cycle in the first IDLE cycle after FLUSH.
REQ-021 pix_ready SHALL equal (state is PRIME or RUN) AND (win_valid=0 OR win_ready=1).
REQ-022 Counter update on every accept: col increments and wraps IMG_WIDTH-1 -> 0; row increments on each col wrap.
REQ-023 A window-completing accept is an accept in RUN state with col>=2, where:
- stride1: any such accept;
- stride2: additionally (col-2) even and (row-2) even.
REQ-024 On a window-completing accept, win_valid SHALL be 1 in the next cycle, aligned with the registered line-buffer taps (latency 1).
- win_col and win_row SHALL be registered in the same cycle: (col-2)>>s and (row-2)>>s, where s = latched stride2.
REQ-025 win_valid SHALL clear when win_ready=1 and no window-completing accept occurs in that cycle.
- On a simultaneous consume and new completion, win_valid SHALL stay 1 and win_col/win_row SHALL update.
REQ-026 While win_valid=1 and win_ready=0:
- win_valid, win_col and win_row SHALL hold;
- pix_ready SHALL be 0, so line-buffer taps are frozen.
REQ-027 Window count per frame SHALL be:
- stride1: (IMG_WIDTH-2)*(IMG_HEIGHT-2);
- stride2: floor((IMG_WIDTH-1)/2)*floor((IMG_HEIGHT-1)/2).
REQ-028 pix_valid=0 gaps SHALL stall counters without state change; no timeout exists.

Reset
REQ-029 While rst_n=0, outputs SHALL immediately be:
- state IDLE;
- pix_ready=0, lb_valid_in=0, win_valid=0, busy=0, frame_done=0;
- win_col=0, win_row=0;
- counters 0, latched stride 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no frame_done.
- The next start SHALL re-prime two full rows before any window is emitted, because line-buffer contents are not trusted.
REQ-031 Deassertion of rst_n SHALL be sampled synchronously; the first start is accepted no earlier than the first clk edge after deassertion.

Verification
REQ-032 W=8, H=6, stride1, pix_valid=1, win_ready=1 -> 24 windows.
- First win_valid occurs 1 cycle after accept #19 (row2, col2).
- Last window is win_col=5, win_row=3.
- One frame_done pulse.
REQ-033 W=8, H=6, stride2 -> 6 windows at (col,row) (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
- win_valid=0 on odd-offset columns.
REQ-034 Hold win_ready=0 for 5 cycles at the first window -> pix_ready=0, lb_valid_in=0 and win_col/win_row stable throughout.
- The window is released on win_ready=1 with no loss or duplication.
- The total still equals 24.
REQ-035 Random pix_valid gaps (50%) and random win_ready (50%) -> identical window sequence to REQ-032.
REQ-036 Assert rst_n=0 in RUN at row 3, then start again -> all outputs 0 during reset and no frame_done for the aborted frame.
- The new frame's first window occurs only after 2 new rows (accept #19).
REQ-037 Assert start during RUN and during FLUSH -> ignored: counters unaffected and the latched stride is unchanged.
